register_file_v1: RTL and testbench

// - RISC-V integer register file, 32 x 32-bit, x0 hard-wired to zero.
// - Two address ports; each serves as a read port and, per rdwr_config, as a write port.
// - Sits between decode and writeback in the riscv_core datapath.
// - link_reg redirects port-1 writes to x1 (ra) for JAL/JALR.
// - Exports an 8-bit error/debug vector.

---
 rtl/regfile_pkg.sv | 33 +++
 rtl/regfile_write_decode.sv | 45 ++++
 rtl/register_file_v1.sv | 70 +++++++
 tb/tb_register_file_v1.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the RISC-V integer register file.
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;
  localparam int ERR_W  = 8;

  // Meaning of rdwr_config: bit 0 enables port 1 writes, bit 1 enables port 2 writes.
  typedef enum logic [1:0] {
    RF_READ    = 2'b00,
    RF_WR1     = 2'b01,
    RF_WR2     = 2'b10,
    RF_WR_BOTH = 2'b11
  } rdwr_cfg_e;

  // Bit positions inside the error/debug vector; upper bits are reserved.
  localparam int ERR_WR_X0     = 0;
  localparam int ERR_COLLIDE   = 1;
  localparam int ERR_LINK_NOWR = 2;

  // Return address register targeted by JAL/JALR link writes.
  localparam logic [ADDR_W-1:0] RA_ADDR = 5'd1;

  function automatic logic port1_wr_en(input rdwr_cfg_e cfg);
    return (cfg == RF_WR1) || (cfg == RF_WR_BOTH);
  endfunction

  function automatic logic port2_wr_en(input rdwr_cfg_e cfg);
    return (cfg == RF_WR2) || (cfg == RF_WR_BOTH);
  endfunction

endpackage

// File: rtl/regfile_write_decode.sv
// Write decode: turns addresses, config and link_reg into per-register
// write enables, a per-register data select and the raw error flags.
module regfile_write_decode
  import regfile_pkg::*;
(
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [ADDR_W-1:0] i_addr2,
  input  rdwr_cfg_e         i_cfg,
  input  logic              i_link_reg,
  output logic [NREGS-1:0]  o_we,
  output logic [NREGS-1:0]  o_sel2,
  output logic [ERR_W-1:0]  o_err
);

  logic [ADDR_W-1:0] w_dest1;
  logic              w_en1;
  logic              w_en2;

  // A link write always lands in ra, whatever port 1's address says.
  assign w_dest1 = i_link_reg ? RA_ADDR : i_addr1;
  assign w_en1   = port1_wr_en(i_cfg);
  assign w_en2   = port2_wr_en(i_cfg);

  // Per-register enables; x0 is never enabled, so even an unknown address
  // cannot disturb it. Port 2 data is selected whenever port 2 hits, which
  // makes port 2 win a same-destination collision.
  always_comb begin
    o_we   = '0;
    o_sel2 = '0;
    for (int i = 1; i < NREGS; i++) begin
      o_we[i]   = (w_en1 && (w_dest1 == ADDR_W'(i))) ||
                  (w_en2 && (i_addr2 == ADDR_W'(i)));
      o_sel2[i] = w_en2 && (i_addr2 == ADDR_W'(i));
    end
  end

  // Raw error flags for the current cycle; the top registers them.
  always_comb begin
    o_err                = '0;
    o_err[ERR_WR_X0]     = (w_en1 && (w_dest1 == '0)) || (w_en2 && (i_addr2 == '0));
    o_err[ERR_COLLIDE]   = w_en1 && w_en2 && (w_dest1 == i_addr2) && (w_dest1 != '0);
    o_err[ERR_LINK_NOWR] = i_link_reg && !w_en1;
  end

endmodule

// File: rtl/register_file_v1.sv
// RISC-V integer register file: 32 x 32-bit, x0 reads zero, two ports that
// each read combinationally and optionally write on the rising clock edge.
module register_file_v1
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] reg_addr1,
  input  logic [ADDR_W-1:0] reg_addr2,
  input  logic [XLEN-1:0]   wr_data1,
  input  logic [XLEN-1:0]   wr_data2,
  input  logic [1:0]        rdwr_config,
  input  logic              link_reg,
  output logic [XLEN-1:0]   outdata1,
  output logic [XLEN-1:0]   outdata2,
  output logic [ERR_W-1:0]  reg_file_error_vector
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [ERR_W-1:0] r_err;
  logic [NREGS-1:0] w_we;
  logic [NREGS-1:0] w_sel2;
  logic [ERR_W-1:0] w_err;
  rdwr_cfg_e        w_cfg;

  assign w_cfg = rdwr_cfg_e'(rdwr_config);

  regfile_write_decode u_write_decode (
    .i_addr1    (reg_addr1),
    .i_addr2    (reg_addr2),
    .i_cfg      (w_cfg),
    .i_link_reg (link_reg),
    .o_we       (w_we),
    .o_sel2     (w_sel2),
    .o_err      (w_err)
  );

  // Register storage: async clear, then per-register writes (entry 0 stays zero).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (w_we[i]) begin
          r_regs[i] <= w_sel2[i] ? wr_data2 : wr_data1;
        end
      end
    end
  end

  // Error vector captures only the cycle just completed; nothing is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= '0;
    end else begin
      r_err <= w_err;
    end
  end

  // Combinational read muxes with no bypass; address 0 is forced to zero.
  always_comb begin
    outdata1 = (reg_addr1 == '0) ? '0 : r_regs[reg_addr1];
    outdata2 = (reg_addr2 == '0) ? '0 : r_regs[reg_addr2];
  end

  assign reg_file_error_vector = r_err;

endmodule

// File: tb/tb_register_file_v1.sv
// Directed scoreboard bench for register_file_v1.
module tb_register_file_v1;

  logic        clk;
  logic        rst;
  logic [4:0]  reg_addr1;
  logic [4:0]  reg_addr2;
  logic [31:0] wr_data1;
  logic [31:0] wr_data2;
  logic [1:0]  rdwr_config;
  logic        link_reg;
  logic [31:0] outdata1;
  logic [31:0] outdata2;
  logic [7:0]  err_vec;

  // Expected entries are packed as {err[7:0], outdata2[31:0], outdata1[31:0]}.
  logic [71:0] exp_q[$];
  logic [71:0] exp_w;
  int          checks;
  int          errors;
  int          chk_id;
  event        mon_kick;

  register_file_v1 dut (
    .clk                   (clk),
    .rst                   (rst),
    .reg_addr1             (reg_addr1),
    .reg_addr2             (reg_addr2),
    .wr_data1              (wr_data1),
    .wr_data2              (wr_data2),
    .rdwr_config           (rdwr_config),
    .link_reg              (link_reg),
    .outdata1              (outdata1),
    .outdata2              (outdata2),
    .reg_file_error_vector (err_vec)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic drive(input logic [1:0] cfg, input logic lnk,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] d1, input logic [31:0] d2);
    @(posedge clk);
    #1;
    rdwr_config = cfg;
    link_reg    = lnk;
    reg_addr1   = a1;
    reg_addr2   = a2;
    wr_data1    = d1;
    wr_data2    = d2;
  endtask

  task automatic expect_out(input logic [31:0] e1, input logic [31:0] e2, input logic [7:0] ee);
    exp_q.push_back({ee, e2, e1});
  endtask

  // Monitor / scoreboard: compares every queued expectation against the
  // outputs present at the next negedge (or an explicit mid-cycle kick).
  initial begin
    checks = 0;
    errors = 0;
    chk_id = 0;
    forever begin
      @(negedge clk or mon_kick);
      while (exp_q.size() > 0) begin
        exp_w  = exp_q.pop_front();
        chk_id = chk_id + 1;
        checks = checks + 1;
        if (outdata1 !== exp_w[31:0]) begin
          errors = errors + 1;
          $display("FAIL chk%0d outdata1 got %h exp %h", chk_id, outdata1, exp_w[31:0]);
        end
        checks = checks + 1;
        if (outdata2 !== exp_w[63:32]) begin
          errors = errors + 1;
          $display("FAIL chk%0d outdata2 got %h exp %h", chk_id, outdata2, exp_w[63:32]);
        end
        checks = checks + 1;
        if (err_vec !== exp_w[71:64]) begin
          errors = errors + 1;
          $display("FAIL chk%0d err_vec got %h exp %h", chk_id, err_vec, exp_w[71:64]);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    rst         = 1'b0;
    rdwr_config = 2'b00;
    link_reg    = 1'b0;
    reg_addr1   = 5'd0;
    reg_addr2   = 5'd0;
    wr_data1    = 32'h0;
    wr_data2    = 32'h0;
    expect_out(32'h0, 32'h0, 8'h00);          // state while held in reset
    #12;
    rst = 1'b1;

    // x0 writes are discarded and flagged
    drive(2'b11, 1'b0, 5'd0, 5'd0, 32'd5, 32'd5);  expect_out(32'h0, 32'h0, 8'h00);
    drive(2'b00, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);  expect_out(32'h0, 32'h0, 8'h01);
    // port-1 write, old value visible until the edge
    drive(2'b01, 1'b0, 5'd3, 5'd3, 32'hDEADBEEF, 32'h0); expect_out(32'h0, 32'h0, 8'h00);
    drive(2'b00, 1'b0, 5'd3, 5'd3, 32'h0, 32'h0);  expect_out(32'hDEADBEEF, 32'hDEADBEEF, 8'h00);
    // collision: port 2 wins
    drive(2'b11, 1'b0, 5'd7, 5'd7, 32'd1, 32'd2);  expect_out(32'h0, 32'h0, 8'h00);
    drive(2'b00, 1'b0, 5'd7, 5'd7, 32'h0, 32'h0);  expect_out(32'd2, 32'd2, 8'h02);
    // link write goes to x1, x9 untouched
    drive(2'b01, 1'b1, 5'd9, 5'd1, 32'h1234, 32'h0); expect_out(32'h0, 32'h0, 8'h00);
    drive(2'b00, 1'b0, 5'd9, 5'd1, 32'h0, 32'h0);  expect_out(32'h0, 32'h1234, 8'h00);
    // link without port-1 write: flag for one cycle only
    drive(2'b00, 1'b1, 5'd3, 5'd7, 32'h11, 32'h22); expect_out(32'hDEADBEEF, 32'd2, 8'h00);
    drive(2'b00, 1'b0, 5'd3, 5'd7, 32'h0, 32'h0);  expect_out(32'hDEADBEEF, 32'd2, 8'h04);
    drive(2'b00, 1'b0, 5'd3, 5'd7, 32'h0, 32'h0);  expect_out(32'hDEADBEEF, 32'd2, 8'h00);
    // port-2-only write, then dual write to distinct registers
    drive(2'b10, 1'b0, 5'd5, 5'd5, 32'hAAAA, 32'h55); expect_out(32'h0, 32'h0, 8'h00);
    drive(2'b11, 1'b0, 5'd10, 5'd11, 32'hA0, 32'hB1); expect_out(32'h0, 32'h0, 8'h00);
    drive(2'b00, 1'b0, 5'd5, 5'd10, 32'h0, 32'h0);  expect_out(32'h55, 32'hA0, 8'h00);
    drive(2'b00, 1'b0, 5'd11, 5'd5, 32'h0, 32'h0);  expect_out(32'hB1, 32'h55, 8'h00);
    // link destination colliding with port 2 on x1
    drive(2'b11, 1'b1, 5'd20, 5'd1, 32'hCAFE, 32'hF00D); expect_out(32'h0, 32'h1234, 8'h00);
    drive(2'b00, 1'b0, 5'd20, 5'd1, 32'h0, 32'h0);  expect_out(32'h0, 32'hF00D, 8'h02);
    // port-1-only x0 write flagged; x31 boundary via port 2
    drive(2'b01, 1'b0, 5'd0, 5'd31, 32'h77, 32'h0);  expect_out(32'h0, 32'h0, 8'h00);
    drive(2'b10, 1'b0, 5'd31, 5'd31, 32'h0, 32'hFFFFFFFF); expect_out(32'h0, 32'h0, 8'h01);
    drive(2'b00, 1'b0, 5'd31, 5'd0, 32'h0, 32'h0);  expect_out(32'hFFFFFFFF, 32'h0, 8'h00);

    // fill x1..x31 with their index
    for (int i = 1; i < 32; i++) begin
      drive(2'b01, 1'b0, 5'(i), 5'd0, 32'(i), 32'h0);
    end
    drive(2'b00, 1'b1, 5'd31, 5'd17, 32'h0, 32'h0); expect_out(32'd31, 32'd17, 8'h00);
    drive(2'b00, 1'b0, 5'd31, 5'd17, 32'h0, 32'h0); expect_out(32'd31, 32'd17, 8'h04);
    // async reset pulse between edges
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    expect_out(32'h0, 32'h0, 8'h00);
    -> mon_kick;
    #1;
    rst = 1'b1;
    drive(2'b00, 1'b0, 5'd31, 5'd17, 32'h0, 32'h0); expect_out(32'h0, 32'h0, 8'h00);
    drive(2'b00, 1'b0, 5'd1, 5'd30, 32'h0, 32'h0);  expect_out(32'h0, 32'h0, 8'h00);
    // writes work again after reset
    drive(2'b01, 1'b0, 5'd2, 5'd2, 32'd9, 32'h0);   expect_out(32'h0, 32'h0, 8'h00);
    drive(2'b00, 1'b0, 5'd2, 5'd2, 32'h0, 32'h0);   expect_out(32'd9, 32'd9, 8'h00);

    // final report
    @(negedge clk);
    #1;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain queue left %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
